// File: rtl/mcp_seq_pkg.sv
// Package: mcp_seq_pkg
// Purpose : Shared types and constants for the multicycle-path launch/capture
//           sequencer (mcp_launch_capture_seq) and its hold counter.
// Contents:
//   mcp_state_t  sequencer state encoding
//   STATS_W      width of the optional statistics counters
//   satInc       saturating increment used by the statistics counters
package mcp_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        HOLD,
        CAPTURE,
        RESP
    } mcp_state_t;

    localparam int STATS_W = 16;

    // Counters stick at all-ones instead of wrapping to zero.
    function automatic logic [STATS_W-1:0] satInc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/mcp_hold_counter.sv
// Module : mcp_hold_counter
// Purpose: Down-counter that measures the launch-to-capture distance of the
//          sequencer. It is loaded on accept (or cleared on abort) and
//          decremented once per HOLD cycle; 'last' tells the FSM that the
//          current HOLD cycle is the final one.
// Ports  :
//   clk1   in   1      clock, all state on posedge
//   rst_n  in   1      asynchronous active-low reset
//   load   in   1      load 'value' at the next edge (wins over dec)
//   value  in   CNT_W  value to load
//   dec    in   1      decrement at the next edge (stops at zero)
//   cnt    out  CNT_W  current count
//   last   out  1      cnt == 1
module mcp_hold_counter
    import mcp_seq_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    // Decrement stops at zero so a stray dec can never wrap to all-ones.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mcp_launch_capture_seq.sv
// Module : mcp_launch_capture_seq
// Purpose: Sequencer for a launch->capture register pair constrained as a
//          multicycle path. One request at a time is accepted, launch_en is
//          pulsed, exactly SETUP_CYCLES clock periods later capture_en is
//          pulsed, and the captured word is returned on a valid/ready response.
// Optional feature: define MCP_SEQ_STATS_EN to add the saturating statistics
//          outputs done_cnt and abort_cnt.
// Ports  :
//   clk1         in   1       clock
//   rst_n        in   1       asynchronous active-low reset
//   req_valid    in   1       request present
//   req_ready    out  1       sequencer can accept (IDLE only)
//   req_data     in   DATA_W  word to launch
//   abort        in   1       synchronous cancel, any state -> IDLE
//   launch_en    out  1       1-cycle load enable for the source register
//   launch_data  out  DATA_W  registered req_data, held until next accept
//   capture_en   out  1       1-cycle load enable for the destination register
//   cap_data     in   DATA_W  destination path output, sampled end of CAPTURE
//   rsp_valid    out  1       response held until consumed
//   rsp_ready    in   1       response sink ready
//   rsp_data     out  DATA_W  captured word
//   done_cnt     out  16      completed responses (MCP_SEQ_STATS_EN only)
//   abort_cnt    out  16      aborts taken outside IDLE (MCP_SEQ_STATS_EN only)
//   busy         out  1       high in any state except IDLE
module mcp_launch_capture_seq
    import mcp_seq_pkg::*;
#(
    parameter int  DATA_W       = 8,
    parameter int  SETUP_CYCLES = 2,
    localparam int CNT_W        = $clog2(SETUP_CYCLES + 1)
) (
    input  logic               clk1,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_data,
    input  logic               abort,
    output logic               launch_en,
    output logic [DATA_W-1:0]  launch_data,
    output logic               capture_en,
    input  logic [DATA_W-1:0]  cap_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
`ifdef MCP_SEQ_STATS_EN
    output logic [STATS_W-1:0] done_cnt,
    output logic [STATS_W-1:0] abort_cnt,
`endif
    output logic               busy
);

    // A zero-cycle multicycle path is meaningless; refuse to elaborate.
    generate
        if (SETUP_CYCLES < 1) begin : g_badSetup
            $error("mcp_launch_capture_seq: SETUP_CYCLES must be >= 1");
        end
    endgenerate

    mcp_state_t        r_state;
    mcp_state_t        w_nextState;
    logic [DATA_W-1:0] r_launchData;
    logic [DATA_W-1:0] r_rspData;
    logic              w_accept;
    logic              w_cntLoad;
    logic [CNT_W-1:0]  w_cntValue;
    logic              w_cntDec;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_cntLast;

    // Abort blocks an accept even when a request is waiting in IDLE.
    assign w_accept = (r_state == IDLE) && req_valid && !abort;

    // The counter is preset to SETUP_CYCLES-1 on accept so that HOLD lasts
    // exactly SETUP_CYCLES-1 cycles; an abort clears it.
    assign w_cntLoad  = w_accept || abort;
    assign w_cntValue = abort ? '0 : CNT_W'(SETUP_CYCLES - 1);
    assign w_cntDec   = (r_state == HOLD);

    mcp_hold_counter #(
        .CNT_W (CNT_W)
    ) u_holdCounter (
        .clk1  (clk1),
        .rst_n (rst_n),
        .load  (w_cntLoad),
        .value (w_cntValue),
        .dec   (w_cntDec),
        .cnt   (w_cnt),
        .last  (w_cntLast)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and Moore outputs. Abort overrides every transition, but the
    // capture_en of a CAPTURE cycle is still emitted since it is decoded from
    // the current state only. In HOLD a zero count is treated like the last
    // cycle so the FSM can never stall there.
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        launch_en   = 1'b0;
        capture_en  = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_nextState = LAUNCH;
                end
            end
            LAUNCH: begin
                launch_en   = 1'b1;
                w_nextState = (SETUP_CYCLES == 1) ? CAPTURE : HOLD;
            end
            HOLD: begin
                if (w_cntLast || (w_cnt == '0)) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                capture_en  = 1'b1;
                w_nextState = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        if (abort) begin
            w_nextState = IDLE;
        end
    end

    // The response word is only taken when the capture actually completes;
    // an aborted capture leaves the previous response word in place.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_launchData <= '0;
            r_rspData    <= '0;
        end else begin
            if (w_accept) begin
                r_launchData <= req_data;
            end
            if ((r_state == CAPTURE) && !abort) begin
                r_rspData <= cap_data;
            end
        end
    end

    assign launch_data = r_launchData;
    assign rsp_data    = r_rspData;

`ifdef MCP_SEQ_STATS_EN
    logic [STATS_W-1:0] r_doneCnt;
    logic [STATS_W-1:0] r_abortCnt;
    logic               w_rspFire;
    logic               w_abortTaken;

    // A handshake that coincides with abort is counted as an abort only.
    assign w_rspFire    = (r_state == RESP) && rsp_ready && !abort;
    assign w_abortTaken = abort && (r_state != IDLE);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_doneCnt  <= '0;
            r_abortCnt <= '0;
        end else begin
            if (w_rspFire) begin
                r_doneCnt <= satInc(r_doneCnt);
            end
            if (w_abortTaken) begin
                r_abortCnt <= satInc(r_abortCnt);
            end
        end
    end

    assign done_cnt  = r_doneCnt;
    assign abort_cnt = r_abortCnt;
`endif

endmodule

// File: tb/tb_mcp_launch_capture_seq.sv
// Bench for mcp_launch_capture_seq. Two instances run side by side:
// dut0 with SETUP_CYCLES=2 and dut1 with SETUP_CYCLES=1, each with its own
// inputs. A behavioural model tracks, per instance, how many cycles have passed
// since the accept and derives every output from that distance. A single
// compare process checks all outputs of both instances every cycle, plus the
// literal expectations ("pins") queued by the directed stimulus.
module tb_mcp_launch_capture_seq;

    localparam int N0 = 2;
    localparam int N1 = 1;

    localparam int P_RSPDATA0    = 0;
    localparam int P_RSPVALID0   = 1;
    localparam int P_LAUNCHEN0   = 2;
    localparam int P_CAPEN0      = 3;
    localparam int P_REQREADY0   = 4;
    localparam int P_BUSY0       = 5;
    localparam int P_LAUNCHDATA0 = 6;
    localparam int P_RSPDATA1    = 7;
    localparam int P_RSPVALID1   = 8;
    localparam int P_LAUNCHEN1   = 9;
    localparam int P_CAPEN1      = 10;
    localparam int P_BUSY1       = 11;
    localparam int P_DONE0       = 12;
    localparam int P_ABORT0      = 13;

    logic       clk1 = 1'b0;
    logic       rst_n = 1'b0;

    logic       reqValid   [2];
    logic [7:0] reqData    [2];
    logic       abortIn    [2];
    logic [7:0] capData    [2];
    logic       rspReady   [2];
    logic       reqReady   [2];
    logic       launchEn   [2];
    logic [7:0] launchData [2];
    logic       captureEn  [2];
    logic       rspValid   [2];
    logic [7:0] rspData    [2];
    logic       busy       [2];
`ifdef MCP_SEQ_STATS_EN
    logic [15:0] doneCnt   [2];
    logic [15:0] abortCnt  [2];
`endif

    int compared   = 0;
    int mismatched = 0;

    int          pinCnt = 0;
    int          pinSel [6];
    logic [15:0] pinExp [6];
    bit          statsForced = 1'b0;

    always #5 clk1 = ~clk1;

    mcp_launch_capture_seq #(
        .DATA_W       (8),
        .SETUP_CYCLES (N0)
    ) dut0 (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .req_valid   (reqValid[0]),
        .req_ready   (reqReady[0]),
        .req_data    (reqData[0]),
        .abort       (abortIn[0]),
        .launch_en   (launchEn[0]),
        .launch_data (launchData[0]),
        .capture_en  (captureEn[0]),
        .cap_data    (capData[0]),
        .rsp_valid   (rspValid[0]),
        .rsp_ready   (rspReady[0]),
        .rsp_data    (rspData[0]),
`ifdef MCP_SEQ_STATS_EN
        .done_cnt    (doneCnt[0]),
        .abort_cnt   (abortCnt[0]),
`endif
        .busy        (busy[0])
    );

    mcp_launch_capture_seq #(
        .DATA_W       (8),
        .SETUP_CYCLES (N1)
    ) dut1 (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .req_valid   (reqValid[1]),
        .req_ready   (reqReady[1]),
        .req_data    (reqData[1]),
        .abort       (abortIn[1]),
        .launch_en   (launchEn[1]),
        .launch_data (launchData[1]),
        .capture_en  (captureEn[1]),
        .cap_data    (capData[1]),
        .rsp_valid   (rspValid[1]),
        .rsp_ready   (rspReady[1]),
        .rsp_data    (rspData[1]),
`ifdef MCP_SEQ_STATS_EN
        .done_cnt    (doneCnt[1]),
        .abort_cnt   (abortCnt[1]),
`endif
        .busy        (busy[1])
    );

    // ---------------- behavioural model (owned by the compare process) ----
    bit          mActive [2] = '{1'b0, 1'b0};
    int          mK      [2] = '{0, 0};
    logic [7:0]  mLaunch [2] = '{8'h00, 8'h00};
    logic [7:0]  mRsp    [2] = '{8'h00, 8'h00};
`ifdef MCP_SEQ_STATS_EN
    logic [15:0] mDone   [2] = '{16'h0, 16'h0};
    logic [15:0] mAbort  [2] = '{16'h0, 16'h0};
    bit          forceSeen = 1'b0;
`endif

    function automatic int setupOf(input int inst);
        return (inst == 0) ? N0 : N1;
    endfunction

    function automatic logic [15:0] probe(input int sel);
        case (sel)
            P_RSPDATA0:    return 16'(rspData[0]);
            P_RSPVALID0:   return 16'(rspValid[0]);
            P_LAUNCHEN0:   return 16'(launchEn[0]);
            P_CAPEN0:      return 16'(captureEn[0]);
            P_REQREADY0:   return 16'(reqReady[0]);
            P_BUSY0:       return 16'(busy[0]);
            P_LAUNCHDATA0: return 16'(launchData[0]);
            P_RSPDATA1:    return 16'(rspData[1]);
            P_RSPVALID1:   return 16'(rspValid[1]);
            P_LAUNCHEN1:   return 16'(launchEn[1]);
            P_CAPEN1:      return 16'(captureEn[1]);
            P_BUSY1:       return 16'(busy[1]);
`ifdef MCP_SEQ_STATS_EN
            P_DONE0:       return doneCnt[0];
            P_ABORT0:      return abortCnt[0];
`endif
            default:       return 16'hDEAD;
        endcase
    endfunction

    function automatic string pinName(input int sel);
        case (sel)
            P_RSPDATA0:    return "pin rsp_data0";
            P_RSPVALID0:   return "pin rsp_valid0";
            P_LAUNCHEN0:   return "pin launch_en0";
            P_CAPEN0:      return "pin capture_en0";
            P_REQREADY0:   return "pin req_ready0";
            P_BUSY0:       return "pin busy0";
            P_LAUNCHDATA0: return "pin launch_data0";
            P_RSPDATA1:    return "pin rsp_data1";
            P_RSPVALID1:   return "pin rsp_valid1";
            P_LAUNCHEN1:   return "pin launch_en1";
            P_CAPEN1:      return "pin capture_en1";
            P_BUSY1:       return "pin busy1";
            P_DONE0:       return "pin done_cnt0";
            P_ABORT0:      return "pin abort_cnt0";
            default:       return "pin unknown";
        endcase
    endfunction

    task automatic cmp(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s inst%0d @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic modelReset(input int i);
        mActive[i] = 1'b0;
        mK[i]      = 0;
        mLaunch[i] = 8'h00;
        mRsp[i]    = 8'h00;
`ifdef MCP_SEQ_STATS_EN
        mDone[i]   = 16'h0;
        mAbort[i]  = 16'h0;
`endif
    endtask

    // Expected outputs follow from the distance k since the accept:
    // launch at k=1, capture at k=N+1, response from k=N+2 until consumed.
    task automatic checkOutput;
        int  ns;
        logic eLaunch, eCap, eRspV;
`ifdef MCP_SEQ_STATS_EN
        if (statsForced && !forceSeen) begin
            mDone[0]  = 16'hFFFF;
            mAbort[0] = 16'hFFFF;
            forceSeen = 1'b1;
        end
`endif
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) modelReset(i);
            ns      = setupOf(i);
            eLaunch = mActive[i] && (mK[i] == 1);
            eCap    = mActive[i] && (mK[i] == ns + 1);
            eRspV   = mActive[i] && (mK[i] >= ns + 2);
            cmp("req_ready",   i, 16'(reqReady[i]),   16'(!mActive[i]));
            cmp("busy",        i, 16'(busy[i]),       16'(mActive[i]));
            cmp("launch_en",   i, 16'(launchEn[i]),   16'(eLaunch));
            cmp("capture_en",  i, 16'(captureEn[i]),  16'(eCap));
            cmp("rsp_valid",   i, 16'(rspValid[i]),   16'(eRspV));
            cmp("launch_data", i, 16'(launchData[i]), 16'(mLaunch[i]));
            cmp("rsp_data",    i, 16'(rspData[i]),    16'(mRsp[i]));
`ifdef MCP_SEQ_STATS_EN
            cmp("done_cnt",    i, doneCnt[i],         mDone[i]);
            cmp("abort_cnt",   i, abortCnt[i],        mAbort[i]);
`endif
        end
        for (int p = 0; p < pinCnt; p++) begin
            cmp(pinName(pinSel[p]), 0, probe(pinSel[p]), pinExp[p]);
        end
    endtask

    task automatic modelUpdate;
        int ns;
        for (int i = 0; i < 2; i++) begin
            ns = setupOf(i);
            if (!rst_n) begin
                modelReset(i);
            end else if (abortIn[i]) begin
`ifdef MCP_SEQ_STATS_EN
                if (mActive[i] && (mAbort[i] != 16'hFFFF)) mAbort[i] = mAbort[i] + 16'h1;
`endif
                mActive[i] = 1'b0;
            end else if (!mActive[i]) begin
                if (reqValid[i]) begin
                    mActive[i] = 1'b1;
                    mK[i]      = 1;
                    mLaunch[i] = reqData[i];
                end
            end else begin
                if (mK[i] == ns + 1) mRsp[i] = capData[i];
                if ((mK[i] >= ns + 2) && rspReady[i]) begin
                    mActive[i] = 1'b0;
`ifdef MCP_SEQ_STATS_EN
                    if (mDone[i] != 16'hFFFF) mDone[i] = mDone[i] + 16'h1;
`endif
                end else begin
                    mK[i] = mK[i] + 1;
                end
            end
        end
    endtask

    // Compare on the falling edge, advance the model on the rising edge.
    always begin
        @(negedge clk1);
        checkOutput();
        @(posedge clk1);
        modelUpdate();
    end

    // ---------------- directed stimulus ----------------------------------
    task automatic step;
        @(posedge clk1);
        #1;
        pinCnt = 0;
    endtask

    task automatic pin(input int sel, input logic [15:0] exp);
        pinSel[pinCnt] = sel;
        pinExp[pinCnt] = exp;
        pinCnt++;
    endtask

    task automatic applyStimulus(input int inst, input logic v, input logic [7:0] d,
                                 input logic ab, input logic [7:0] c, input logic rr);
        reqValid[inst] = v;
        reqData[inst]  = d;
        abortIn[inst]  = ab;
        capData[inst]  = c;
        rspReady[inst] = rr;
    endtask

    task automatic runTxn(input int inst, input logic [7:0] d, input logic [7:0] c);
        step(); applyStimulus(inst, 1'b1, d, 1'b0, c, 1'b0);
        step(); applyStimulus(inst, 1'b0, 8'h00, 1'b0, c, 1'b0);
        repeat (setupOf(inst) + 1) step();
        pin((inst == 0) ? P_RSPVALID0 : P_RSPVALID1, 16'h1);
        pin((inst == 0) ? P_RSPDATA0 : P_RSPDATA1, 16'(c));
        applyStimulus(inst, 1'b0, 8'h00, 1'b0, c, 1'b1);
        step(); applyStimulus(inst, 1'b0, 8'h00, 1'b0, c, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(posedge clk1);
        #1;
        // reset state
        pin(P_REQREADY0, 16'h1); pin(P_BUSY0, 16'h0);
        pin(P_LAUNCHDATA0, 16'h0); pin(P_RSPDATA0, 16'h0);
        step(); rst_n = 1'b1;
        pin(P_REQREADY0, 16'h1);

        // Test 1: N=2, A5 in, 5A captured
        step(); applyStimulus(0, 1'b1, 8'hA5, 1'b0, 8'h5A, 1'b0); pin(P_REQREADY0, 16'h1);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h5A, 1'b0);
        pin(P_LAUNCHEN0, 16'h1); pin(P_LAUNCHDATA0, 16'hA5); pin(P_BUSY0, 16'h1);
        step(); pin(P_LAUNCHEN0, 16'h0); pin(P_CAPEN0, 16'h0);
        step(); pin(P_CAPEN0, 16'h1);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        pin(P_RSPVALID0, 16'h1); pin(P_RSPDATA0, 16'h5A); pin(P_CAPEN0, 16'h0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        pin(P_RSPVALID0, 16'h0); pin(P_REQREADY0, 16'h1); pin(P_LAUNCHDATA0, 16'hA5);

        // Test 2: N=1, capture directly after launch, then abort in CAPTURE
        step(); applyStimulus(1, 1'b1, 8'h3C, 1'b0, 8'hC3, 1'b0);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b0); pin(P_LAUNCHEN1, 16'h1);
        step(); pin(P_CAPEN1, 16'h1); pin(P_LAUNCHEN1, 16'h0);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        pin(P_RSPVALID1, 16'h1); pin(P_RSPDATA1, 16'hC3);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0); pin(P_BUSY1, 16'h0);
        step(); applyStimulus(1, 1'b1, 8'h77, 1'b0, 8'h88, 1'b0);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h88, 1'b0);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b1, 8'h88, 1'b0); pin(P_CAPEN1, 16'h1);
        step(); applyStimulus(1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        pin(P_RSPVALID1, 16'h0); pin(P_BUSY1, 16'h0); pin(P_RSPDATA1, 16'hC3);

        // Test 3: response back-pressure, requests ignored until consumed
        step(); applyStimulus(0, 1'b1, 8'h11, 1'b0, 8'h22, 1'b0);
        step(); applyStimulus(0, 1'b1, 8'h99, 1'b0, 8'h22, 1'b0);
        step(); step(); step();
        for (int k = 0; k < 5; k++) begin
            pin(P_RSPVALID0, 16'h1); pin(P_RSPDATA0, 16'h22); pin(P_REQREADY0, 16'h0);
            step(); applyStimulus(0, 1'b1, 8'h99, 1'b0, 8'(k * 37 + 5), 1'b0);
        end
        applyStimulus(0, 1'b1, 8'h99, 1'b0, 8'h66, 1'b1); pin(P_RSPVALID0, 16'h1);
        step(); applyStimulus(0, 1'b1, 8'h99, 1'b0, 8'h66, 1'b0); pin(P_REQREADY0, 16'h1);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h66, 1'b0);
        pin(P_LAUNCHEN0, 16'h1); pin(P_LAUNCHDATA0, 16'h99);
        step(); step();
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h66, 1'b1); pin(P_RSPDATA0, 16'h66);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Test 4: abort in HOLD, then abort together with a request in IDLE
        step(); applyStimulus(0, 1'b1, 8'h44, 1'b0, 8'h55, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0); pin(P_BUSY0, 16'h1);
        step(); applyStimulus(0, 1'b1, 8'hAB, 1'b1, 8'h55, 1'b0);
        pin(P_BUSY0, 16'h0); pin(P_CAPEN0, 16'h0); pin(P_REQREADY0, 16'h1);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0);
        pin(P_LAUNCHEN0, 16'h0); pin(P_BUSY0, 16'h0); pin(P_LAUNCHDATA0, 16'h44);
        step(); pin(P_RSPVALID0, 16'h0); pin(P_RSPDATA0, 16'h66);

        // Test 5: reset asserted mid-HOLD, fresh request afterwards
        step(); applyStimulus(0, 1'b1, 8'h5E, 1'b0, 8'hE5, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'hE5, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        pin(P_REQREADY0, 16'h1); pin(P_BUSY0, 16'h0);
        pin(P_LAUNCHDATA0, 16'h0); pin(P_LAUNCHEN0, 16'h0);
        step(); rst_n = 1'b1; pin(P_CAPEN0, 16'h0); pin(P_RSPVALID0, 16'h0);
        runTxn(0, 8'h6D, 8'hD6);
        pin(P_LAUNCHDATA0, 16'h6D);

`ifdef MCP_SEQ_STATS_EN
        // Test 6: statistics after reset, then saturation
        runTxn(0, 8'h01, 8'h10);
        runTxn(0, 8'h02, 8'h20);
        step(); applyStimulus(0, 1'b1, 8'h03, 1'b0, 8'h30, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b1, 8'h30, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h30, 1'b0);
        pin(P_DONE0, 16'd3); pin(P_ABORT0, 16'd1);
        step();
        force dut0.r_doneCnt = 16'hFFFF;
        force dut0.r_abortCnt = 16'hFFFF;
        release dut0.r_doneCnt;
        release dut0.r_abortCnt;
        statsForced = 1'b1;
        pin(P_DONE0, 16'hFFFF);
        runTxn(0, 8'h04, 8'h40);
        step(); applyStimulus(0, 1'b1, 8'h05, 1'b0, 8'h50, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b1, 8'h50, 1'b0);
        step(); applyStimulus(0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0);
        pin(P_DONE0, 16'hFFFF); pin(P_ABORT0, 16'hFFFF);
`endif

        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
